// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I core widths, reset vector and fetch entry type
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched {instr, pc} entries with flush
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  assign head = r_mem[r_rd];
  assign count = r_count;
  assign full = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  // pointers wrap naturally because DEPTH is a power of two; flush drops everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr] <= din;
        r_wr <= r_wr + AW'(1);
      end
      if (pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch PC, imem addressing and decoupling queue to decode
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  logic [XLEN-1:0] r_pc;
  fetch_entry_t w_din, w_head;
  logic [AW:0] w_count;
  logic w_full, w_empty, w_pop, w_push, w_unused;
  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign w_pop = out_valid && out_ready;
  assign w_push = !redirect_valid && (!w_full || w_pop);
  assign w_din = {imem_data, r_pc};
  assign out_instr = w_head.instr;
  assign out_pc = w_head.pc;
  assign out_pc_plus4 = w_head.pc + 32'd4;
  assign w_unused = &{1'b0, redirect_pc[1:0], w_count};
  // fetch PC: redirect wins over sequential advance, which only happens on push
  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (w_push) r_pc <= r_pc + 32'd4;
  end
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(w_push),
    .pop(w_pop),
    .din(w_din),
    .head(w_head),
    .count(w_count),
    .full(w_full),
    .empty(w_empty)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with scoreboard-checked output stream
module tb_fetch_stage;
  logic clk = 0, rst = 1, redirect_valid = 0, out_ready = 1, out_valid;
  logic [31:0] imem_addr, imem_data, redirect_pc = 0, out_instr, out_pc, out_pc_plus4;
  logic [31:0] rom [32];
  logic [63:0] exp_q [$];
  int checks = 0, errors = 0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );
  assign imem_data = rom[imem_addr[6:2]];
  always #5 clk = ~clk;
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h required %h", n, a, e);
    end
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({rom[pc[6:2]], pc});
  endtask
  task automatic do_reset();
    out_ready = 0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  // monitor: every completed transfer must match the next expected entry
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer got pc %h required no transfer", out_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e[31:0]);
        chk("out_instr", out_instr, e[63:32]);
        chk("out_pc_plus4", out_pc_plus4, e[31:0] + 32'd4);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    rom[0] = 32'h005303b3;
    rom[16] = 32'h00100093;
    rom[17] = 32'h00200113;
    rom[31] = 32'hfe000ee3;
    // reset and first fetches
    step();
    chk("rst_valid", {31'b0, out_valid}, 0);
    step();
    chk("rst_valid2", {31'b0, out_valid}, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_plus4", out_pc_plus4, 4);
    chk("rst_addr", imem_addr, 0);
    rst = 0;
    chk("first_addr", imem_addr, 0);
    chk("first_valid", {31'b0, out_valid}, 0);
    expect_pc(0); expect_pc(4); expect_pc(8); expect_pc(12);
    step();
    chk("first_valid_next", {31'b0, out_valid}, 1);
    step(); step(); step();
    step();
    // backpressure
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 1);
      chk("bp_pc", out_pc, 0);
      chk("bp_instr", out_instr, 32'h005303b3);
      if (i > 0) chk("bp_addr", imem_addr, 8);
      step();
    end
    out_ready = 1;
    expect_pc(0); expect_pc(4); expect_pc(8); expect_pc(12);
    step(); step(); step(); step();
    // redirect with full queue
    do_reset();
    step(); step();
    chk("full_addr", imem_addr, 8);
    chk("full_pc", out_pc, 0);
    redirect_valid = 1;
    redirect_pc = 32'h40;
    out_ready = 1;
    expect_pc(0);
    step();
    redirect_valid = 0;
    chk("redir_valid", {31'b0, out_valid}, 0);
    chk("redir_addr", imem_addr, 32'h40);
    expect_pc(32'h40); expect_pc(32'h44);
    step();
    chk("redir_valid2", {31'b0, out_valid}, 1);
    chk("redir_pc", out_pc, 32'h40);
    step();
    step();
    out_ready = 0;
    // misaligned redirect
    redirect_valid = 1;
    redirect_pc = 32'h43;
    step();
    redirect_valid = 0;
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_valid", {31'b0, out_valid}, 0);
    out_ready = 1;
    expect_pc(32'h40);
    step();
    chk("mis_pc", out_pc, 32'h40);
    // wrap redirect, issued while the head transfers
    redirect_valid = 1;
    redirect_pc = 32'hffff_fffc;
    step();
    redirect_valid = 0;
    chk("wrap_valid", {31'b0, out_valid}, 0);
    chk("wrap_addr", imem_addr, 32'hffff_fffc);
    expect_pc(32'hffff_fffc); expect_pc(0);
    step();
    chk("wrap_plus4", out_pc_plus4, 0);
    chk("wrap_addr2", imem_addr, 0);
    step();
    step();
    out_ready = 0;
    step();
    chk("pre_rst_addr", imem_addr, 32'hc);
    chk("pre_rst_pc", out_pc, 4);
    // reset with redirect on a full queue
    rst = 1;
    redirect_valid = 1;
    redirect_pc = 32'h60;
    step();
    rst = 0;
    redirect_valid = 0;
    chk("mrst_valid", {31'b0, out_valid}, 0);
    chk("mrst_pc", out_pc, 0);
    chk("mrst_instr", out_instr, 0);
    chk("mrst_addr", imem_addr, 0);
    out_ready = 1;
    expect_pc(0); expect_pc(4);
    step();
    chk("mrst_addr2", imem_addr, 4);
    step();
    step();
    out_ready = 0;
    step();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
